// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit for the E stage.
// Holds architectural HI/LO, executes mult/div/mt/mf ops, and reports busy
// while a multi-cycle compute op is in flight.
// Compile-time option: define MDU_MADD_EN to build the multiply-accumulate
// ops (madd/maddu/msub/msubu); without it those op codes are no-ops.
module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    // Counter is sized for the longer of the two latencies.
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    logic              issue;
    logic              is_div_op;
    logic              is_mul_op;
    logic              is_compute;
    logic              commit;

    // Multiply datapath (operates on latched operands)
    logic              mul_signed;
    logic [2*WIDTH-1:0] mul_a_ext;
    logic [2*WIDTH-1:0] mul_b_ext;
    logic [2*WIDTH-1:0] product;

    // Divide datapath (operates on latched operands)
    logic              div_signed;
    logic              a_neg;
    logic              b_neg;
    logic              div_zero;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH-1:0]  b_safe;
    logic [WIDTH-1:0]  q_mag;
    logic [WIDTH-1:0]  r_mag;
    logic [WIDTH-1:0]  quotient;
    logic [WIDTH-1:0]  remainder;

`ifdef MDU_MADD_EN
    logic              acc_sub;
    logic [2*WIDTH-1:0] acc_cur;
    logic [2*WIDTH-1:0] acc_new;
`endif

    // Decode the incoming op and qualify issue (only accepted while idle).
    always_comb begin
        is_div_op = (op == OP_DIV) || (op == OP_DIVU);
        is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul_op = is_mul_op || (op == OP_MADD) || (op == OP_MADDU) ||
                    (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        is_compute = is_div_op || is_mul_op;
        issue      = start && !flush && (state_q == S_IDLE);
        commit     = (state_q == S_RUN) && (cnt_q == '0);
    end

    // Full-width product; sign- or zero-extension selects signed/unsigned.
    always_comb begin
        mul_signed = (op_q == OP_MULT);
`ifdef MDU_MADD_EN
        mul_signed = mul_signed || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
        mul_a_ext = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        mul_b_ext = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        product   = mul_a_ext * mul_b_ext;
    end

    // Divide via magnitudes; quotient truncates toward zero and the
    // remainder follows the dividend sign. Most-negative / -1 falls out
    // naturally: the magnitude wraps back to the most-negative pattern.
    always_comb begin
        div_signed = (op_q == OP_DIV);
        a_neg      = div_signed && a_q[WIDTH-1];
        b_neg      = div_signed && b_q[WIDTH-1];
        div_zero   = (b_q == '0);
        a_mag      = a_neg ? (~a_q + 1'b1) : a_q;
        b_mag      = b_neg ? (~b_q + 1'b1) : b_q;
        // Divisor forced nonzero so the divider never sees x/0; the result
        // is discarded in that case anyway.
        b_safe     = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quotient   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        remainder  = a_neg ? (~r_mag + 1'b1) : r_mag;
    end

`ifdef MDU_MADD_EN
    // Accumulate against HI/LO as they stand at the commit edge.
    always_comb begin
        acc_sub = (op_q == OP_MSUB) || (op_q == OP_MSUBU);
        acc_cur = {hi_q, lo_q};
        acc_new = acc_sub ? (acc_cur - product) : (acc_cur + product);
    end
`endif

    // FSM next state: IDLE -> RUN on compute issue, RUN -> IDLE on expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (issue && is_compute) begin
                    state_d = S_RUN;
                    cnt_d   = is_div_op ? DIV_LOAD : MULT_LOAD;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Datapath next state: operand latch at issue, mt writes, result commit.
    always_comb begin
        op_d = op_q;
        a_d  = a_q;
        b_d  = b_q;
        hi_d = hi_q;
        lo_d = lo_q;
        if (issue) begin
            if (op == OP_MTHI) begin
                hi_d = a;
            end else if (op == OP_MTLO) begin
                lo_d = a;
            end else if (is_compute) begin
                op_d = op;
                a_d  = a;
                b_d  = b;
            end
        end
        if (commit) begin
            case (op_q)
                OP_MULT, OP_MULTU: begin
                    hi_d = product[2*WIDTH-1:WIDTH];
                    lo_d = product[WIDTH-1:0];
                end
                OP_DIV, OP_DIVU: begin
                    if (!div_zero) begin
                        hi_d = remainder;
                        lo_d = quotient;
                    end
                end
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                    hi_d = acc_new[2*WIDTH-1:WIDTH];
                    lo_d = acc_new[WIDTH-1:0];
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Control state register; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath registers; reset wins over a same-edge commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            op_q <= op_d;
            a_q  <= a_d;
            b_q  <= b_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Outputs; mf_out is a zero-latency read port selected by the live op.
    always_comb begin
        busy = (state_q == S_RUN);
        hi   = hi_q;
        lo   = lo_q;
        case (op)
            OP_MFHI: mf_out = hi_q;
            OP_MFLO: mf_out = lo_q;
            default: mf_out = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed, table-driven bench for mdu_seq (default parameters).
module tb_mdu_seq;

`ifdef MDU_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_out;

    int checks = 0;
    int errors = 0;

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .mf_out (mf_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one issue edge, then scramble operands.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        op    = 4'd0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Count cycles busy is observed high, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        int busy_seen;

        vecs[0]  = '{4'd1,  32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{4'd2,  32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{4'd1,  32'hFFFFFFFD, 32'h00000005, 5,  32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[3]  = '{4'd1,  32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};
        vecs[4]  = '{4'd3,  32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5]  = '{4'd4,  32'h00000007, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[7]  = '{4'd4,  32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
        vecs[8]  = '{4'd3,  32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{4'd3,  32'h00000007, 32'h00000000, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{4'd7,  32'h00000000, 32'h00000000, 0,  32'h00000000, 32'hFFFFFFFD};
        vecs[11] = '{4'd8,  32'hFFFFFFFF, 32'h00000000, 0,  32'h00000000, 32'hFFFFFFFF};
        vecs[12] = '{4'd10, 32'h00000001, 32'h00000001, MADD ? 5 : 0,
                     MADD ? 32'h00000001 : 32'h00000000, MADD ? 32'h00000000 : 32'hFFFFFFFF};
        vecs[13] = '{4'd9,  32'hFFFFFFFF, 32'h00000001, MADD ? 5 : 0,
                     32'h00000000, 32'hFFFFFFFF};
        vecs[14] = '{4'd12, 32'h00000002, 32'h00000003, MADD ? 5 : 0,
                     32'h00000000, MADD ? 32'hFFFFFFF9 : 32'hFFFFFFFF};
        vecs[15] = '{4'd11, 32'hFFFFFFFF, 32'h00000002, MADD ? 5 : 0,
                     32'h00000000, MADD ? 32'hFFFFFFFB : 32'hFFFFFFFF};
        vecs[16] = '{4'd0,  32'h00000005, 32'h00000005, 0,
                     32'h00000000, MADD ? 32'hFFFFFFFB : 32'hFFFFFFFF};
        vecs[17] = '{4'd15, 32'h00000005, 32'h00000005, 0,
                     32'h00000000, MADD ? 32'hFFFFFFFB : 32'hFFFFFFFF};

        // Reset state
        reset = 1'b0;
        repeat (3) step();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b1;
        step();

        // mthi then mf reads (mt latency 1, mf zero latency)
        issue(4'd7, 32'h00001234, 32'h0);
        $display("mthi 0x1234 -> hi %h lo %h busy %0d", hi, lo, busy);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        op = 4'd6; #1;
        chk("mflo_after_mthi", mf_out, 32'h0);
        op = 4'd5; #1;
        chk("mfhi_after_mthi", mf_out, 32'h00001234);
        op = 4'd0; #1;
        chk("mf_other_op", mf_out, 32'h0);

        // Second mult while busy is ignored
        issue(4'd1, 32'd3, 32'd4);
        step();
        start = 1'b1; op = 4'd1; a = 32'd5; b = 32'd6;
        step();
        start = 1'b0; op = 4'd0;
        wait_idle(n);
        $display("mult 3*4 with ignored mult 5*6 -> hi %h lo %h", hi, lo);
        chk("ignored_busy_cycles", n, 32'd3);
        chk("ignored_lo", lo, 32'd12);
        chk("ignored_hi", hi, 32'd0);
        step();
        chk("ignored_no_second_run", {31'd0, busy}, 32'd0);

        // Flush pulse during RUN does not abort
        issue(4'd1, 32'd7, 32'd6);
        step();
        flush = 1'b1; start = 1'b1; op = 4'd1; a = 32'd1; b = 32'd1;
        step();
        flush = 1'b0; start = 1'b0; op = 4'd0;
        wait_idle(n);
        $display("mult 7*6 with flush in RUN -> hi %h lo %h", hi, lo);
        chk("flush_run_cycles", n, 32'd3);
        chk("flush_run_lo", lo, 32'd42);

        // Flush in issue cycle blocks compute and mt
        start = 1'b1; flush = 1'b1; op = 4'd1; a = 32'd9; b = 32'd9;
        step();
        chk("flush_issue_busy", {31'd0, busy}, 32'd0);
        op = 4'd7; a = 32'hDEAD;
        step();
        start = 1'b0; flush = 1'b0; op = 4'd0;
        $display("flushed mult/mthi -> hi %h lo %h busy %0d", hi, lo, busy);
        chk("flush_issue_busy2", {31'd0, busy}, 32'd0);
        chk("flush_issue_lo", lo, 32'd42);
        chk("flush_issue_hi", hi, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle(n);
            $display("vec %0d op %0d a %h b %h -> busy %0d hi %h lo %h",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, n, hi, lo);
            chk($sformatf("vec%0d_busy_cycles", i), n, vecs[i].n);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            op = 4'd5; #1;
            chk($sformatf("vec%0d_mfhi", i), mf_out, vecs[i].hi);
            op = 4'd6; #1;
            chk($sformatf("vec%0d_mflo", i), mf_out, vecs[i].lo);
            op = 4'd0;
            step();
        end

        // Reset during cycle 3 of a divide discards it
        issue(4'd3, 32'd100, 32'd3);
        step();
        step();
        reset = 1'b0;
        step();
        $display("reset mid-divide -> hi %h lo %h busy %0d", hi, lo, busy);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        reset = 1'b1;
        busy_seen = 0;
        repeat (15) begin
            step();
            if (busy) busy_seen++;
        end
        chk("midreset_no_later_busy", busy_seen, 32'd0);
        chk("midreset_no_commit_lo", lo, 32'd0);
        chk("midreset_no_commit_hi", hi, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
